// File: rtl/ahb_lite_interconnect.sv
// Single-master, N-slave AHB-Lite interconnect: address decode, data-phase tracking,
// response mux and a default slave that answers unmapped transfers with a two-cycle ERROR.
module ahb_lite_interconnect #(
  parameter int NUM_SLAVES    = 2,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic [ADDR_WIDTH-1:0]            m_haddr_in,
  input  logic [DATA_WIDTH-1:0]            m_hwdata_in,
  input  logic                             m_hwrite_in,
  input  logic [1:0]                       m_htrans_in,
  input  logic [2:0]                       m_hsize_in,
  input  logic [2:0]                       m_hburst_in,
  input  logic [3:0]                       m_hprot_in,
  input  logic                             m_hmastlock_in,
  output logic [DATA_WIDTH-1:0]            m_hrdata_out,
  output logic                             m_hready_out,
  output logic                             m_hresp_out,
  output logic [NUM_SLAVES-1:0]            s_hsel_out,
  output logic [ADDR_WIDTH-1:0]            s_haddr_out,
  output logic [DATA_WIDTH-1:0]            s_hwdata_out,
  output logic                             s_hwrite_out,
  output logic [1:0]                       s_htrans_out,
  output logic [2:0]                       s_hsize_out,
  output logic [2:0]                       s_hburst_out,
  output logic [3:0]                       s_hprot_out,
  output logic                             s_hmastlock_out,
  output logic                             s_hready_out,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_hrdata_in,
  input  logic [NUM_SLAVES-1:0]            s_hready_in,
  input  logic [NUM_SLAVES-1:0]            s_hresp_in,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_base_addr_in,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_last_addr_in,
  output logic [ERR_CNT_WIDTH-1:0]         err_count_out,
  output logic [ADDR_WIDTH-1:0]            err_addr_out
);

  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {DS_OK, DS_ERR1, DS_ERR2} ds_state_t;

  ds_state_t               ds_state;
  logic                    hit;
  logic [SW-1:0]           hit_idx;
  logic [NUM_SLAVES-1:0]   hsel;
  logic                    dactive;
  logic                    dsel_def;
  logic [SW-1:0]           dsel_idx;
  logic                    sl_ready;
  logic                    sl_resp;
  logic [DATA_WIDTH-1:0]   sl_rdata;
  logic                    ds_hready;
  logic                    ds_hresp;
  logic                    unmapped_xfer;

  // Lowest-index region wins, so hsel can never carry more than one bit.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hsel    = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!hit &&
          m_haddr_in >= s_base_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH] &&
          m_haddr_in <= s_last_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
        hsel[i] = 1'b1;
      end
    end
  end

  assign s_hsel_out      = hsel;
  assign s_haddr_out     = m_haddr_in;
  assign s_hwdata_out    = m_hwdata_in;
  assign s_hwrite_out    = m_hwrite_in;
  assign s_htrans_out    = m_htrans_in;
  assign s_hsize_out     = m_hsize_in;
  assign s_hburst_out    = m_hburst_in;
  assign s_hprot_out     = m_hprot_in;
  assign s_hmastlock_out = m_hmastlock_in;
  assign s_hready_out    = m_hready_out;

  assign unmapped_xfer = m_hready_out && !hit && m_htrans_in[1];

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dactive  <= 1'b0;
      dsel_def <= 1'b1;
      dsel_idx <= '0;
    end else if (m_hready_out) begin
      dactive  <= m_htrans_in[1];
      dsel_def <= !hit;
      dsel_idx <= hit_idx;
    end
  end

  // Default slave and error log share the acceptance condition of an unmapped transfer.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ds_state      <= DS_OK;
      err_count_out <= '0;
      err_addr_out  <= '0;
    end else begin
      case (ds_state)
        DS_OK:   if (unmapped_xfer) ds_state <= DS_ERR1;
        DS_ERR1: ds_state <= DS_ERR2;
        DS_ERR2: ds_state <= unmapped_xfer ? DS_ERR1 : DS_OK;
        default: ds_state <= DS_OK;
      endcase
      if (unmapped_xfer) begin
        err_addr_out <= m_haddr_in;
        if (err_count_out != '1) err_count_out <= err_count_out + 1'b1;
      end
    end
  end

  assign ds_hready = (ds_state != DS_ERR1);
  assign ds_hresp  = (ds_state != DS_OK);

  always_comb begin
    sl_ready = 1'b1;
    sl_resp  = 1'b0;
    sl_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_idx == SW'(i)) begin
        sl_ready = s_hready_in[i];
        sl_resp  = s_hresp_in[i];
        sl_rdata = s_hrdata_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    m_hready_out = 1'b1;
    m_hresp_out  = 1'b0;
    m_hrdata_out = '0;
    if (dactive) begin
      if (dsel_def) begin
        m_hready_out = ds_hready;
        m_hresp_out  = ds_hresp;
      end else begin
        m_hready_out = sl_ready;
        m_hresp_out  = sl_resp;
        m_hrdata_out = sl_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Bench for ahb_lite_interconnect with three slave regions; expected data-phase
// responses are queued when an address phase is driven and popped after each edge.
module tb_ahb_lite_interconnect;

  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int RW = DW + 2;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  localparam logic [DW-1:0] D0 = 32'h1111_0000;
  localparam logic [DW-1:0] D1 = 32'hCAFE_BABE;
  localparam logic [DW-1:0] D2 = 32'h2222_2222;

  localparam logic [AW-1:0] DEC_ADDR [10] = '{
    32'h0000_0000, 32'h0000_FFFF, 32'h0001_0000, 32'h0001_FFFF, 32'h0002_0000,
    32'h4000_0000, 32'h4000_00FF, 32'h4000_0100, 32'h3FFF_FFFF, 32'h8000_0000};
  localparam logic [NS-1:0] DEC_SEL [10] = '{
    3'b001, 3'b001, 3'b010, 3'b010, 3'b000,
    3'b100, 3'b100, 3'b000, 3'b000, 3'b000};

  logic                 HCLK = 1'b0;
  logic                 HRESETn;
  logic [AW-1:0]        m_haddr_in;
  logic [DW-1:0]        m_hwdata_in;
  logic                 m_hwrite_in;
  logic [1:0]           m_htrans_in;
  logic [2:0]           m_hsize_in;
  logic [2:0]           m_hburst_in;
  logic [3:0]           m_hprot_in;
  logic                 m_hmastlock_in;
  logic [DW-1:0]        m_hrdata_out;
  logic                 m_hready_out;
  logic                 m_hresp_out;
  logic [NS-1:0]        s_hsel_out;
  logic [AW-1:0]        s_haddr_out;
  logic [DW-1:0]        s_hwdata_out;
  logic                 s_hwrite_out;
  logic [1:0]           s_htrans_out;
  logic [2:0]           s_hsize_out;
  logic [2:0]           s_hburst_out;
  logic [3:0]           s_hprot_out;
  logic                 s_hmastlock_out;
  logic                 s_hready_out;
  logic [NS*DW-1:0]     s_hrdata_in;
  logic [NS-1:0]        s_hready_in;
  logic [NS-1:0]        s_hresp_in;
  logic [NS*AW-1:0]     s_base_addr_in;
  logic [NS*AW-1:0]     s_last_addr_in;
  logic [CW-1:0]        err_count_out;
  logic [AW-1:0]        err_addr_out;

  logic [RW-1:0] exp_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  logic [CW-1:0] exp_cnt;
  logic [AW-1:0] exp_addr;
  logic [RW-1:0] e;
  logic [RW-1:0] resp;

  assign resp = {m_hready_out, m_hresp_out, m_hrdata_out};

  ahb_lite_interconnect #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m_haddr_in(m_haddr_in), .m_hwdata_in(m_hwdata_in), .m_hwrite_in(m_hwrite_in),
    .m_htrans_in(m_htrans_in), .m_hsize_in(m_hsize_in), .m_hburst_in(m_hburst_in),
    .m_hprot_in(m_hprot_in), .m_hmastlock_in(m_hmastlock_in),
    .m_hrdata_out(m_hrdata_out), .m_hready_out(m_hready_out), .m_hresp_out(m_hresp_out),
    .s_hsel_out(s_hsel_out), .s_haddr_out(s_haddr_out), .s_hwdata_out(s_hwdata_out),
    .s_hwrite_out(s_hwrite_out), .s_htrans_out(s_htrans_out), .s_hsize_out(s_hsize_out),
    .s_hburst_out(s_hburst_out), .s_hprot_out(s_hprot_out),
    .s_hmastlock_out(s_hmastlock_out), .s_hready_out(s_hready_out),
    .s_hrdata_in(s_hrdata_in), .s_hready_in(s_hready_in), .s_hresp_in(s_hresp_in),
    .s_base_addr_in(s_base_addr_in), .s_last_addr_in(s_last_addr_in),
    .err_count_out(err_count_out), .err_addr_out(err_addr_out)
  );

  // clock / reset
  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic [AW-1:0] addr, input logic [1:0] trans, input logic wr);
    m_haddr_in  = addr;
    m_htrans_in = trans;
    m_hwrite_in = wr;
    m_hwdata_in = $urandom;
  endtask

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  function automatic logic [AW-1:0] rand_unmapped();
    return 32'h8000_0000 | AW'($urandom);
  endfunction

  task automatic test_reset();
    HRESETn = 1'b0;
    drive(32'h8000_0000, NONSEQ, 1'b0);
    tick();
    tick();
    exp_q.push_back({1'b1, 1'b0, {DW{1'b0}}});
    if (exp_q.size() == 0) e = 'x; else e = exp_q.pop_front();
    vectors++;
    if (resp !== e || s_hready_out !== m_hready_out) begin
      miscompares++;
      $display("FAIL reset_resp got=%h exp=%h", resp, e);
    end
    vectors++;
    if (err_count_out !== '0 || err_addr_out !== '0) begin
      miscompares++;
      $display("FAIL reset_log got cnt=%0d addr=%h exp cnt=0 addr=0", err_count_out, err_addr_out);
    end
    drive(32'h0, IDLE, 1'b0);
    HRESETn  = 1'b1;
    exp_cnt  = '0;
    exp_addr = '0;
  endtask

  task automatic test_decode();
    for (int i = 0; i < 10; i++) begin
      drive(DEC_ADDR[i], IDLE, 1'b0);
      #1;
      vectors++;
      if (s_hsel_out !== DEC_SEL[i] || s_haddr_out !== DEC_ADDR[i]) begin
        miscompares++;
        $display("FAIL decode[%0d] got sel=%b addr=%h exp sel=%b addr=%h",
                 i, s_hsel_out, s_haddr_out, DEC_SEL[i], DEC_ADDR[i]);
      end
    end
    // slave 1 region overlapping the top half of slave 0
    s_base_addr_in[1*AW +: AW] = 32'h0000_8000;
    drive(32'h0000_8000, NONSEQ, 1'b1);
    m_hsize_in = 3'd2; m_hburst_in = 3'd1; m_hprot_in = 4'hA; m_hmastlock_in = 1'b1;
    #1;
    vectors++;
    if (s_hsel_out !== 3'b001 || s_htrans_out !== NONSEQ || s_hwrite_out !== 1'b1 ||
        s_hwdata_out !== m_hwdata_in || s_hsize_out !== 3'd2 || s_hburst_out !== 3'd1 ||
        s_hprot_out !== 4'hA || s_hmastlock_out !== 1'b1) begin
      miscompares++;
      $display("FAIL overlap_broadcast got sel=%b trans=%b size=%0d prot=%h exp sel=001 trans=10 size=2 prot=a",
               s_hsel_out, s_htrans_out, s_hsize_out, s_hprot_out);
    end
    s_base_addr_in[1*AW +: AW] = 32'h0001_0000;
    m_hsize_in = 3'd0; m_hburst_in = 3'd0; m_hprot_in = 4'h0; m_hmastlock_in = 1'b0;
    drive(32'h0, IDLE, 1'b0);
    #1;
  endtask

  task automatic test_read();
    drive(32'h0001_0004, NONSEQ, 1'b0);
    #1;
    vectors++;
    if (s_hsel_out !== 3'b010) begin
      miscompares++;
      $display("FAIL read_hsel got=%b exp=010", s_hsel_out);
    end
    exp_q.push_back({1'b1, 1'b0, D1});
    tick();
    drive(32'h0, IDLE, 1'b0);
    if (exp_q.size() == 0) e = 'x; else e = exp_q.pop_front();
    vectors++;
    if (resp !== e || s_hready_out !== m_hready_out) begin
      miscompares++;
      $display("FAIL read_resp got=%h exp=%h", resp, e);
    end
    exp_q.push_back({1'b1, 1'b0, {DW{1'b0}}});
    tick();
    if (exp_q.size() == 0) e = 'x; else e = exp_q.pop_front();
    vectors++;
    if (resp !== e) begin
      miscompares++;
      $display("FAIL read_idle got=%h exp=%h", resp, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [5];
    logic [DW-1:0] datas [5];
    addrs = '{32'h0001_0004, 32'h4000_0010, 32'h0000_0020, 32'h0001_FFFC, 32'h4000_00FC};
    datas = '{D1, D2, D0, D1, D2};
    for (int i = 0; i < 5; i++) begin
      drive(addrs[i], NONSEQ, 1'($urandom_range(1, 0)));
      exp_q.push_back({1'b1, 1'b0, datas[i]});
      tick();
      if (exp_q.size() == 0) e = 'x; else e = exp_q.pop_front();
      vectors++;
      if (resp !== e) begin
        miscompares++;
        $display("FAIL b2b[%0d] got=%h exp=%h", i, resp, e);
      end
    end
    drive(32'h0, IDLE, 1'b0);
    tick();
  endtask

  task automatic test_unmapped();
    drive(32'h8000_0000, NONSEQ, 1'b0);
    exp_q.push_back({1'b0, 1'b1, {DW{1'b0}}});
    exp_q.push_back({1'b1, 1'b1, {DW{1'b0}}});
    exp_cnt  = sat_inc(exp_cnt);
    exp_addr = 32'h8000_0000;
    for (int c = 0; c < 2; c++) begin
      tick();
      drive(32'h0, IDLE, 1'b0);
      if (exp_q.size() == 0) e = 'x; else e = exp_q.pop_front();
      vectors++;
      if (resp !== e || s_hready_out !== m_hready_out) begin
        miscompares++;
        $display("FAIL unmapped_cycle%0d got=%h exp=%h", c + 1, resp, e);
      end
    end
    vectors++;
    if (err_count_out !== exp_cnt || err_addr_out !== exp_addr) begin
      miscompares++;
      $display("FAIL unmapped_log got cnt=%0d addr=%h exp cnt=%0d addr=%h",
               err_count_out, err_addr_out, exp_cnt, exp_addr);
    end
    tick();
  endtask

  task automatic test_idle_unmapped();
    drive(32'h8000_0000, IDLE, 1'b0);
    exp_q.push_back({1'b1, 1'b0, {DW{1'b0}}});
    tick();
    if (exp_q.size() == 0) e = 'x; else e = exp_q.pop_front();
    vectors++;
    if (resp !== e || err_count_out !== exp_cnt) begin
      miscompares++;
      $display("FAIL idle_unmapped got=%h cnt=%0d exp=%h cnt=%0d", resp, err_count_out, e, exp_cnt);
    end
  endtask

  task automatic test_wait_states();
    drive(32'h0000_0100, NONSEQ, 1'b0);
    for (int c = 0; c < 3; c++) exp_q.push_back({1'b0, 1'b0, D0});
    exp_q.push_back({1'b1, 1'b0, D0});
    tick();
    s_hready_in[0] = 1'b0;
    drive(32'h4000_0010, NONSEQ, 1'b0);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) s_hready_in[0] = 1'b1;
      #1;
      if (exp_q.size() == 0) e = 'x; else e = exp_q.pop_front();
      vectors++;
      if (resp !== e || s_hready_out !== e[RW-1]) begin
        miscompares++;
        $display("FAIL wait_stall[%0d] got=%h hready_s=%b exp=%h", c, resp, s_hready_out, e);
      end
      if (c < 2) tick();
    end
    exp_q.push_back({1'b1, 1'b0, D2});
    tick();
    drive(32'h0, IDLE, 1'b0);
    if (exp_q.size() == 0) e = 'x; else e = exp_q.pop_front();
    vectors++;
    if (resp !== e) begin
      miscompares++;
      $display("FAIL wait_next got=%h exp=%h", resp, e);
    end
    tick();
  endtask

  task automatic test_slave_error();
    drive(32'h0001_0040, NONSEQ, 1'b0);
    exp_q.push_back({1'b0, 1'b1, D1});
    exp_q.push_back({1'b1, 1'b1, D1});
    tick();
    drive(32'h0, IDLE, 1'b0);
    s_hready_in[1] = 1'b0;
    s_hresp_in[1]  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      if (c == 1) begin
        tick();
        s_hready_in[1] = 1'b1;
      end
      #1;
      if (exp_q.size() == 0) e = 'x; else e = exp_q.pop_front();
      vectors++;
      if (resp !== e) begin
        miscompares++;
        $display("FAIL slave_err_cycle%0d got=%h exp=%h", c + 1, resp, e);
      end
    end
    tick();
    s_hresp_in[1] = 1'b0;
    vectors++;
    if (err_count_out !== exp_cnt || resp !== {1'b1, 1'b0, {DW{1'b0}}}) begin
      miscompares++;
      $display("FAIL slave_err_after got=%h cnt=%0d exp cnt=%0d", resp, err_count_out, exp_cnt);
    end
  endtask

  task automatic test_unmapped_saturate();
    logic [AW-1:0] a;
    a = rand_unmapped();
    drive(a, NONSEQ, 1'b0);
    for (int n = 0; n < 260; n++) begin
      exp_q.push_back({1'b0, 1'b1, {DW{1'b0}}});
      exp_q.push_back({1'b1, 1'b1, {DW{1'b0}}});
      exp_cnt  = sat_inc(exp_cnt);
      exp_addr = a;
      tick();
      a = rand_unmapped();
      if (n == 259) drive(a, IDLE, 1'b0);
      else drive(a, NONSEQ, 1'b0);
      if (exp_q.size() == 0) e = 'x; else e = exp_q.pop_front();
      vectors++;
      if (resp !== e || err_count_out !== exp_cnt || err_addr_out !== exp_addr) begin
        miscompares++;
        $display("FAIL sat_err1[%0d] got=%h cnt=%0d addr=%h exp=%h cnt=%0d addr=%h",
                 n, resp, err_count_out, err_addr_out, e, exp_cnt, exp_addr);
      end
      tick();
      if (exp_q.size() == 0) e = 'x; else e = exp_q.pop_front();
      vectors++;
      if (resp !== e) begin
        miscompares++;
        $display("FAIL sat_err2[%0d] got=%h exp=%h", n, resp, e);
      end
    end
    exp_q.push_back({1'b1, 1'b0, {DW{1'b0}}});
    tick();
    if (exp_q.size() == 0) e = 'x; else e = exp_q.pop_front();
    vectors++;
    if (resp !== e || err_count_out !== 8'd255) begin
      miscompares++;
      $display("FAIL sat_final got=%h cnt=%0d exp=%h cnt=255", resp, err_count_out, e);
    end
  endtask

  task automatic test_reset_mid();
    drive(32'h9000_0000, NONSEQ, 1'b0);
    exp_q.push_back({1'b0, 1'b1, {DW{1'b0}}});
    tick();
    drive(32'h0, IDLE, 1'b0);
    if (exp_q.size() == 0) e = 'x; else e = exp_q.pop_front();
    vectors++;
    if (resp !== e || err_addr_out !== 32'h9000_0000) begin
      miscompares++;
      $display("FAIL rstmid_err1 got=%h addr=%h exp=%h addr=90000000", resp, err_addr_out, e);
    end
    HRESETn = 1'b0;
    exp_q.push_back({1'b1, 1'b0, {DW{1'b0}}});
    exp_q.push_back({1'b1, 1'b0, {DW{1'b0}}});
    exp_cnt  = '0;
    exp_addr = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      HRESETn = 1'b1;
      if (exp_q.size() == 0) e = 'x; else e = exp_q.pop_front();
      vectors++;
      if (resp !== e || err_count_out !== exp_cnt || err_addr_out !== exp_addr) begin
        miscompares++;
        $display("FAIL rstmid[%0d] got=%h cnt=%0d addr=%h exp=%h cnt=0 addr=0",
                 c, resp, err_count_out, err_addr_out, e);
      end
    end
  endtask

  // sequencing and final report
  initial begin
    s_hrdata_in    = {D2, D1, D0};
    s_hready_in    = '1;
    s_hresp_in     = '0;
    s_base_addr_in = {32'h4000_0000, 32'h0001_0000, 32'h0000_0000};
    s_last_addr_in = {32'h4000_00FF, 32'h0001_FFFF, 32'h0000_FFFF};
    m_hsize_in     = 3'd0;
    m_hburst_in    = 3'd0;
    m_hprot_in     = 4'h0;
    m_hmastlock_in = 1'b0;
    exp_cnt        = '0;
    exp_addr       = '0;
    drive(32'h0, IDLE, 1'b0);

    test_reset();
    test_decode();
    test_read();
    test_back_to_back();
    test_unmapped();
    test_idle_unmapped();
    test_wait_states();
    test_slave_error();
    test_unmapped_saturate();
    test_reset_mid();

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got=%0d entries exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
